// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: line FSM states and frame geometry.
// Imported by the receiver now and the transmitter later.
package uart_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for asynchronous single-bit inputs.
// Resets to 1 so an idle-high line does not look like an edge.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start detect, mid-bit sampling, and a
// one-entry valid/ready output register with error pulses.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_receive,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CPB   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_index;
  logic [DATA_BITS-1:0] shift;

  logic half_done;
  logic full_done;
  logic slot_free;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (uart_receive),
    .q     (rx)
  );

  assign half_done = (cnt == CNT_HALF);
  assign full_done = (cnt == CNT_FULL);
  // Slot is usable if empty or being drained this very cycle.
  assign slot_free = !data_out_valid || data_out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_index      <= '0;
      shift          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      cnt           <= cnt + 1'b1;
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx) begin
            state <= START;
          end
        end
        START: begin
          if (half_done) begin
            cnt       <= '0;
            bit_index <= '0;
            state     <= rx ? IDLE : DATA;
          end
        end
        DATA: begin
          if (full_done) begin
            cnt              <= '0;
            shift[bit_index] <= rx;
            if (bit_index == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end
        end
        STOP: begin
          if (full_done) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx) begin
              framing_error <= 1'b1;
            end else if (slot_free) begin
              data_out       <= shift;
              data_out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised scoreboard bench for uart_receiver.
// Frames are built bit by bit; a monitor checks every handshake.
module tb_uart_receiver;

  localparam int CF  = 16;
  localparam int BR  = 1;
  localparam int CPB = CF / BR;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uart_receive = 1'b1;
  logic       data_out_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       framing_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int exp_fe = 0;
  int exp_ov = 0;
  int obs_fe = 0;
  int obs_ov = 0;

  bit   rand_ready = 1'b0;
  logic ready_level = 1'b1;

  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_fe = 1'b0;
  logic       prev_ov = 1'b0;

  always #5 clock = ~clock;

  uart_receiver #(
    .CLOCK_FREQUENCY (CF),
    .BAUD_RATE       (BR),
    .SYNC_STAGES     (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .uart_receive   (uart_receive),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    data_out_ready = rand_ready ?
      ($urandom_range(3) != 0) : ready_level;
  end

  always @(negedge clock) begin
    if (reset) begin
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %0h want none",
                   data_out);
        end else begin
          check("data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      if (prev_hold) begin
        check("hold_valid", 32'(data_out_valid), 1);
        check("hold_data", 32'(data_out), 32'(prev_data));
      end
      if (framing_error) obs_fe++;
      if (overrun) obs_ov++;
      if (framing_error || overrun)
        check("pulse_excl", 32'(framing_error & overrun), 0);
      if (framing_error) check("fe_width", 32'(prev_fe), 0);
      if (overrun) check("ov_width", 32'(prev_ov), 0);
    end
    prev_hold = reset && data_out_valid && !data_out_ready;
    prev_data = data_out;
    prev_fe   = framing_error;
    prev_ov   = overrun;
  end

  task automatic drive_bit(input logic b);
    @(posedge clock);
    #1 uart_receive = b;
    repeat (CPB - 1) @(posedge clock);
  endtask

  task automatic idle_bits(input int n);
    if (n > 0) drive_bit(1'b1);
    for (int i = 1; i < n; i++) drive_bit(1'b1);
  endtask

  // Model: a good stop bit delivers the byte unless the slot is
  // known to be occupied; a bad stop bit gives one framing pulse.
  task automatic send_frame(input logic [7:0] b,
                            input logic stop_ok,
                            input bit slot_open);
    if (!stop_ok) exp_fe++;
    else if (slot_open) exp_q.push_back(b);
    else exp_ov++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic phase_check(input string tag);
    check({tag, "_queue"}, 32'(exp_q.size()), 0);
    check({tag, "_fe"}, 32'(obs_fe), 32'(exp_fe));
    check({tag, "_ov"}, 32'(obs_ov), 32'(exp_ov));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic [7:0] partial;

    repeat (3) @(posedge clock);
    #1;
    check("rst_data", 32'(data_out), 0);
    check("rst_valid", 32'(data_out_valid), 0);
    check("rst_fe", 32'(framing_error), 0);
    check("rst_ov", 32'(overrun), 0);
    reset = 1'b1;
    idle_bits(2);

    send_frame(8'hA5, 1'b1, 1'b1);
    idle_bits(2);
    phase_check("t1");

    @(posedge clock);
    #1 uart_receive = 1'b0;
    repeat (4) @(posedge clock);
    #1 uart_receive = 1'b1;
    idle_bits(2);
    phase_check("t2");

    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    check("t3_valid", 32'(data_out_valid), 0);
    phase_check("t3");

    ready_level = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 1'b1, 1'b0);
    idle_bits(1);
    check("t4_data", 32'(data_out), 32'h11);
    check("t4_valid", 32'(data_out_valid), 1);
    check("t4_ov", 32'(obs_ov), 32'(exp_ov));
    ready_level = 1'b1;
    idle_bits(1);
    check("t4_drained", 32'(data_out_valid), 0);
    phase_check("t4");

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle_bits(2);
    phase_check("t5");

    partial = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(partial[i]);
    @(posedge clock);
    #1 uart_receive = partial[3];
    repeat (8) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("t6_data", 32'(data_out), 0);
    check("t6_valid", 32'(data_out_valid), 0);
    check("t6_fe", 32'(framing_error), 0);
    check("t6_ov", 32'(overrun), 0);
    uart_receive = 1'b1;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    idle_bits(2);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle_bits(2);
    phase_check("t6");

    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(4) != 0);
      send_frame(rb, rs, 1'b1);
      if (!rs) idle_bits(1 + $urandom_range(1));
      else idle_bits($urandom_range(2));
    end
    idle_bits(2);
    rand_ready = 1'b0;
    idle_bits(1);
    phase_check("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
